inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
Fetch sequencer for the instruction memory.
- Owns the PC and drives the memory's chip-enable and byte address; the memory returns read data combinationally.
- Buffers fetched words in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the FIFO.
- Stops fetching when the PC leaves the populated memory range.

Parameters:
RESET_PC, 32'h0000_0000, byte address of the first fetch after reset
MEM_WORDS, 1024, number of 32-bit words in instruction memory; valid PCs are 0 .. MEM_WORDS*4-4
DEPTH, 2, FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-high
inst_ce  out  1  instruction memory chip-enable
inst_addr  out  32  byte address to instruction memory (always equals pc)
inst_data  in  32  word read from memory, valid in the same cycle as inst_ce
out_valid  out  1  FIFO head holds an instruction
out_ready  in  1  decode accepts the head this cycle
out_inst  out  32  head instruction word
out_pc  out  32  byte address of the head instruction
redirect_valid  in  1  load a new PC and discard buffered words
redirect_pc  in  32  target byte address
align_err  out  1  sticky; a redirect target had bits [1:0] != 0
range_err  out  1  sticky; the PC reached an address >= MEM_WORDS*4

Behaviour:
Reset (async, rst=1):
- pc=RESET_PC, FIFO empty (count=0).
- inst_ce=0, out_valid=0, align_err=0, range_err=0.
- out_inst=0, out_pc=0.

Fetch enable and push:
- inst_ce = (count < DEPTH) && !redirect_valid && (pc < MEM_WORDS*4). It is combinational from registers and redirect_valid; out_ready does not affect it.
- When inst_ce=1, the clock edge pushes {pc, inst_data} at the FIFO tail and sets pc <= pc+4.

Pop and output:
- Pop happens when out_valid && out_ready; the head advances at the edge.
- out_valid = (count != 0). out_inst/out_pc are the head entry and hold stable while out_valid && !out_ready.
- Push and pop in the same cycle: count unchanged. At count==DEPTH there is no push (no bypass of a full FIFO).
- Latency: a word fetched at edge N is visible on out_* after edge N. Sustained throughput is 1 instruction/cycle with out_ready held high.

Redirect (redirect_valid=1 at an edge):
- A pop in the same cycle is honoured; this is how decode consumes the branch delay slot.
- All entries are then discarded (count=0) and pc <= {redirect_pc[31:2], 2'b00}.
- No push occurs that cycle.
- align_err sets if redirect_pc[1:0] != 0.
- Fetching resumes the following cycle.
- Back-to-back redirects: the last one wins, and nothing is fetched in between.

Out of range:
- pc >= MEM_WORDS*4 means no fetch and pc holds.
- range_err sets on the first such cycle and stays set until rst.
- Buffered entries still drain normally.
- Only a redirect to an in-range target resumes fetching.
- 32-bit PC wrap cannot occur, because range_err stops fetching first.

Reset mid-operation: FIFO contents are lost immediately and the outputs return to their reset values asynchronously.

Sticky flags clear only on rst.

Decomposition:
- Shared package holds:
  - INST_BYTES = 4
  - RESET_PC default
  - NOP word 32'h0000_0000
  - fetch entry typedef {pc[31:0], inst[31:0]}
- One natural sub-module: fetch_fifo (parameterised DEPTH, push/pop/flush, count, head entry). The top level keeps the pc register, the enable logic and the error flags.

Test Plan:
- Reset, then release with out_ready=1 and memory words 0..3 = A,B,C,D -> inst_ce high from cycle 1. Decode receives (pc 0,A), (4,B), (8,C), (C,D) on consecutive cycles with out_valid continuous.
- Hold out_ready=0 for 5 cycles -> count reaches 2 and inst_ce drops; pc=8; out_inst stays at word 0. Raising out_ready drains 0, 4 and then 8 without gaps.
- Redirect_valid with target 0x40, in the same cycle as a pop of pc 0x4 -> the pop is accepted and the FIFO is flushed. Next fetch address is 0x40, and the next out_pc is 0x40 (never 0x8).
- Redirect to 0x42 -> inst_addr=0x40 next cycle; align_err=1 and stays 1 through later redirects.
- MEM_WORDS=4, free run from 0 -> words at 0x0..0xC are delivered; at pc=0x10 inst_ce=0 and range_err=1. Redirect to 0x0 resumes fetching.
- Assert rst mid-stream with count=2 -> out_valid=0 and inst_ce=0 with no clock edge needed; after release the first out_pc is RESET_PC.

Source files
------------

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Pure declarations: no latency, no backpressure.
package inst_fetch_ctrl_pkg;

  localparam int unsigned INST_BYTES       = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0000_0000, inst: NOP_WORD};

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_fifo.sv
// Fetch buffer: DEPTH-entry FIFO of {pc, inst}; pushed entry visible at head after one edge.
// Caller must not push when full or pop when empty; flush drops everything in one edge.
module inst_fetch_ctrl_fifo
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [$clog2(DEPTH):0] count,
  output logic         full,
  output fetch_entry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign full = (count == CW'(DEPTH));
  assign head = (count != '0) ? mem[rd_ptr] : EMPTY_ENTRY;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns PC, reads imem combinationally, buffers words for decode; 1-cycle fetch-to-out latency.
// Fetch stalls while the buffer is full, during a redirect, or once the PC leaves memory.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned DEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_ce,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        align_err,
  output logic        range_err
);

  localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS * INST_BYTES);
  localparam logic [31:0] PC_STEP  = 32'(INST_BYTES);

  logic [31:0]           pc;
  logic [31:0]           pc_nxt;
  logic                  pc_in_range;
  logic                  pop;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                  fifo_full;
  fetch_entry_t          fifo_head;
  fetch_entry_t          push_entry;

  assign pc_in_range = (pc < PC_LIMIT);
  // Gated by rst so the enable drops immediately on an asynchronous reset.
  assign inst_ce     = !rst && !fifo_full && !redirect_valid && pc_in_range;
  assign inst_addr   = pc;
  assign out_valid   = (fifo_count != '0);
  assign pop         = out_valid && out_ready;
  assign push_entry  = '{pc: pc, inst: inst_data};

  always_comb begin
    pc_nxt = pc;
    if (redirect_valid) pc_nxt = word_align(redirect_pc);
    else if (inst_ce)   pc_nxt = pc + PC_STEP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      align_err <= 1'b0;
      range_err <= 1'b0;
    end else begin
      pc <= pc_nxt;
      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) align_err <= 1'b1;
      if (pc_nxt >= PC_LIMIT) range_err <= 1'b1;
    end
  end

  inst_fetch_ctrl_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inst_ce),
    .push_entry(push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .full      (fifo_full),
    .head      (fifo_head)
  );

  assign out_inst = fifo_head.inst;
  assign out_pc   = fifo_head.pc;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed vector table, async-reset sequence, random run against a queue model.
module tb_inst_fetch_ctrl;

  localparam int unsigned MEM_WORDS = 32;
  localparam int unsigned DEPTH     = 2;
  localparam logic [31:0] LIMIT     = 32'h80;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_ce;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        align_err;
  logic        range_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0] ^ 16'h1234};
  endfunction

  assign inst_data = memw(inst_addr);

  inst_fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .MEM_WORDS(MEM_WORDS),
    .DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_ce       (inst_ce),
    .inst_addr     (inst_addr),
    .inst_data     (inst_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .align_err     (align_err),
    .range_err     (range_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_ce, input logic [31:0] e_addr,
                         input logic e_valid, input logic [31:0] e_pc,
                         input logic e_aerr, input logic e_rerr);
    chk({tag, ".ce"},    32'(inst_ce),   32'(e_ce));
    chk({tag, ".addr"},  inst_addr,      e_addr);
    chk({tag, ".valid"}, 32'(out_valid), 32'(e_valid));
    chk({tag, ".pc"},    out_pc,         e_valid ? e_pc : 32'h0);
    chk({tag, ".inst"},  out_inst,       e_valid ? memw(e_pc) : 32'h0);
    chk({tag, ".aerr"},  32'(align_err), 32'(e_aerr));
    chk({tag, ".rerr"},  32'(range_err), 32'(e_rerr));
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        e_ce;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_aerr;
    logic        e_rerr;
  } vec_t;

  function automatic vec_t v(input logic rdy, input logic rv, input logic [31:0] rpc,
                             input logic e_ce, input logic [31:0] e_addr, input logic e_valid,
                             input logic [31:0] e_pc, input logic e_aerr, input logic e_rerr);
    vec_t r;
    r.rdy = rdy; r.rv = rv; r.rpc = rpc; r.e_ce = e_ce; r.e_addr = e_addr;
    r.e_valid = e_valid; r.e_pc = e_pc; r.e_aerr = e_aerr; r.e_rerr = e_rerr;
    return r;
  endfunction

  // Reference model state: buffered PCs in order, plus PC and sticky flags.
  logic [31:0] mq[$];
  logic [31:0] m_pc;
  logic        m_aerr;
  logic        m_rerr;

  vec_t vecs[$];

  initial begin
    logic [31:0] rpc;
    logic        m_ce;

    rst            = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #2;
    chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    //            rdy rv  rpc    ce  addr   vld pc     aerr rerr
    vecs.push_back(v(1, 0, 32'h0,  1, 32'h00, 0, 32'h00, 0, 0));
    vecs.push_back(v(1, 0, 32'h0,  1, 32'h04, 1, 32'h00, 0, 0));
    vecs.push_back(v(1, 0, 32'h0,  1, 32'h08, 1, 32'h04, 0, 0));
    vecs.push_back(v(1, 0, 32'h0,  1, 32'h0C, 1, 32'h08, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,  1, 32'h10, 1, 32'h0C, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,  0, 32'h14, 1, 32'h0C, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,  0, 32'h14, 1, 32'h0C, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,  0, 32'h14, 1, 32'h0C, 0, 0));
    vecs.push_back(v(1, 0, 32'h0,  0, 32'h14, 1, 32'h0C, 0, 0));
    vecs.push_back(v(1, 0, 32'h0,  1, 32'h14, 1, 32'h10, 0, 0));
    vecs.push_back(v(1, 1, 32'h40, 0, 32'h18, 1, 32'h14, 0, 0));
    vecs.push_back(v(1, 0, 32'h0,  1, 32'h40, 0, 32'h00, 0, 0));
    vecs.push_back(v(1, 0, 32'h0,  1, 32'h44, 1, 32'h40, 0, 0));
    vecs.push_back(v(1, 1, 32'h42, 0, 32'h48, 1, 32'h44, 0, 0));
    vecs.push_back(v(1, 0, 32'h0,  1, 32'h40, 0, 32'h00, 1, 0));
    vecs.push_back(v(1, 1, 32'h70, 0, 32'h44, 1, 32'h40, 1, 0));
    vecs.push_back(v(1, 1, 32'h74, 0, 32'h70, 0, 32'h00, 1, 0));
    vecs.push_back(v(1, 0, 32'h0,  1, 32'h74, 0, 32'h00, 1, 0));
    vecs.push_back(v(1, 0, 32'h0,  1, 32'h78, 1, 32'h74, 1, 0));
    vecs.push_back(v(1, 0, 32'h0,  1, 32'h7C, 1, 32'h78, 1, 0));
    vecs.push_back(v(1, 0, 32'h0,  0, 32'h80, 1, 32'h7C, 1, 1));
    vecs.push_back(v(1, 0, 32'h0,  0, 32'h80, 0, 32'h00, 1, 1));
    vecs.push_back(v(1, 1, 32'h0,  0, 32'h80, 0, 32'h00, 1, 1));
    vecs.push_back(v(0, 0, 32'h0,  1, 32'h00, 0, 32'h00, 1, 1));
    vecs.push_back(v(0, 0, 32'h0,  1, 32'h04, 1, 32'h00, 1, 1));
    vecs.push_back(v(0, 0, 32'h0,  0, 32'h08, 1, 32'h00, 1, 1));

    foreach (vecs[i]) begin
      out_ready      = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i].e_ce, vecs[i].e_addr, vecs[i].e_valid,
              vecs[i].e_pc, vecs[i].e_aerr, vecs[i].e_rerr);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset with a full buffer: outputs clear with no clock edge.
    rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk_all("post_rst0", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_all("post_rst1", 1'b1, 32'h4, 1'b1, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Random traffic against the queue model, with periodic resets.
    for (int i = 0; i < 2000; i++) begin
      rst            = (i % 400 == 0);
      out_ready      = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 8) == 0;
      rpc            = $urandom_range(0, 32'hA0);
      if (i < 1000 || ($urandom % 4) != 0) rpc[1:0] = 2'b00;
      redirect_pc    = rpc;
      if (rst) begin
        mq.delete();
        m_pc   = 32'h0;
        m_aerr = 1'b0;
        m_rerr = 1'b0;
      end
      m_ce = !rst && (mq.size() < DEPTH) && !redirect_valid && (m_pc < LIMIT);
      @(negedge clk);
      chk_all($sformatf("rnd%0d", i), m_ce, m_pc, mq.size() != 0,
              (mq.size() != 0) ? mq[0] : 32'h0, m_aerr, m_rerr);
      @(posedge clk);
      if (!rst) begin
        if (mq.size() != 0 && out_ready) void'(mq.pop_front());
        if (redirect_valid) begin
          mq.delete();
          m_pc = {redirect_pc[31:2], 2'b00};
          if (redirect_pc[1:0] != 2'b00) m_aerr = 1'b1;
        end else if (m_ce) begin
          mq.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
        if (m_pc >= LIMIT) m_rerr = 1'b1;
      end
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
